// File: rtl/pc_gen.sv
// Fetch-stage program counter: boot/run/halt control, four redirect sources,
// and misaligned-target trapping with capture of the offending address.
module pc_gen #(
    parameter int               WIDTH        = 32,
    parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
    parameter int               INC          = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             redirect,
    input  logic [1:0]       pc_sel,
    input  logic [WIDTH-1:0] imm,
    input  logic [WIDTH-1:0] rs1,
    input  logic [WIDTH-1:0] mtvec,
    input  logic             halt,
    input  logic             resume,
    output logic [WIDTH-1:0] PC_out,
    output logic [WIDTH-1:0] PC_plus,
    output logic             fetch_valid,
    output logic             misalign,
    output logic [WIDTH-1:0] bad_addr
);
    typedef enum logic [1:0] {BOOT, RUN, HALTED} state_t;

    localparam logic [WIDTH-1:0] INC_W = WIDTH'(INC);

    state_t           r_state;
    logic [WIDTH-1:0] r_pc;
    logic [WIDTH-1:0] r_bad;
    logic             r_fv;
    logic             r_mis;

    logic [WIDTH-1:0] w_seq;
    logic [WIDTH-1:0] w_trap;
    logic [WIDTH-1:0] w_tgt;
    logic [WIDTH-1:0] w_next;
    logic             w_chk;
    logic             w_bad;

    assign w_seq  = r_pc + INC_W;
    assign w_trap = mtvec & ~WIDTH'(3);

    always_comb begin
        w_tgt = w_seq;
        w_chk = 1'b0;
        case (pc_sel)
            2'b00: w_tgt = w_seq;
            2'b01: begin
                w_tgt = r_pc + imm;
                w_chk = 1'b1;
            end
            2'b10: begin
                w_tgt = (rs1 + imm) & ~WIDTH'(1);
                w_chk = 1'b1;
            end
            2'b11: w_tgt = w_trap;
            default: w_tgt = w_seq;
        endcase
    end

    // Any low-bit set on a branch/JALR target diverts to the trap vector.
    assign w_bad  = w_chk && (w_tgt[1:0] != 2'b00);
    assign w_next = redirect ? (w_bad ? w_trap : w_tgt) :
                    stall    ? r_pc : w_seq;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= BOOT;
            r_pc    <= RESET_VECTOR;
            r_fv    <= 1'b0;
            r_mis   <= 1'b0;
            r_bad   <= '0;
        end else begin
            r_mis <= 1'b0;
            case (r_state)
                BOOT: begin
                    r_state <= halt ? HALTED : RUN;
                    r_fv    <= !halt;
                end
                RUN: begin
                    r_pc <= w_next;
                    if (redirect && w_bad) begin
                        r_mis <= 1'b1;
                        r_bad <= w_tgt;
                    end
                    if (halt) begin
                        r_state <= HALTED;
                        r_fv    <= 1'b0;
                    end
                end
                HALTED: begin
                    // halt has priority over resume
                    if (resume && !halt) begin
                        r_state <= RUN;
                        r_fv    <= 1'b1;
                    end
                end
                default: begin
                    r_state <= BOOT;
                    r_fv    <= 1'b0;
                end
            endcase
        end
    end

    assign PC_out      = r_pc;
    assign PC_plus     = r_pc + INC_W;
    assign fetch_valid = r_fv;
    assign misalign    = r_mis;
    assign bad_addr    = r_bad;
endmodule

// File: tb/tb_pc_gen.sv
// Directed scoreboard bench for pc_gen: expected PC/valid/misalign pushed per
// driven cycle, popped and compared one time unit after the clock edge.
module tb_pc_gen;
    logic        clk = 1'b0;
    logic        rst;
    logic        stall, redirect, halt, resume;
    logic [1:0]  pc_sel;
    logic [31:0] imm, rs1, mtvec;
    logic [31:0] PC_out, PC_plus, bad_addr;
    logic        fetch_valid, misalign;

    typedef struct {
        string       tag;
        logic [31:0] pc;
        logic        fv;
        logic        mis;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    pc_gen #(.WIDTH(32), .RESET_VECTOR(32'h100), .INC(4)) dut (
        .clk(clk), .rst(rst), .stall(stall), .redirect(redirect),
        .pc_sel(pc_sel), .imm(imm), .rs1(rs1), .mtvec(mtvec),
        .halt(halt), .resume(resume), .PC_out(PC_out), .PC_plus(PC_plus),
        .fetch_valid(fetch_valid), .misalign(misalign), .bad_addr(bad_addr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic step(input string tag, input logic [31:0] pc, input logic fv, input logic mis);
        exp_t e;
        sb.push_back('{tag, pc, fv, mis});
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk({e.tag, "_pc"}, PC_out, e.pc);
        chk({e.tag, "_fv"}, {31'd0, fetch_valid}, {31'd0, e.fv});
        chk({e.tag, "_mis"}, {31'd0, misalign}, {31'd0, e.mis});
        chk({e.tag, "_plus"}, PC_plus, e.pc + 32'd4);
    endtask

    initial begin
        rst = 1'b1; stall = 0; redirect = 0; halt = 0; resume = 0;
        pc_sel = 2'b00; imm = '0; rs1 = '0; mtvec = '0;
        #12;
        chk("rst_pc", PC_out, 32'h100);
        chk("rst_fv", {31'd0, fetch_valid}, 32'd0);
        chk("rst_mis", {31'd0, misalign}, 32'd0);
        chk("rst_bad", bad_addr, 32'd0);
        rst = 1'b0;

        // boot then sequential
        step("boot", 32'h100, 1, 0);
        step("seq1", 32'h104, 1, 0);
        step("seq2", 32'h108, 1, 0);

        // stall vs redirect
        redirect = 1; pc_sel = 2'b01; imm = 32'hFFFF_FF18;
        step("to20", 32'h20, 1, 0);
        redirect = 0; stall = 1;
        step("stall1", 32'h20, 1, 0);
        step("stall2", 32'h20, 1, 0);
        step("stall3", 32'h20, 1, 0);
        redirect = 1; pc_sel = 2'b01; imm = 32'hFFFF_FFF0;
        step("flush", 32'h10, 1, 0);
        imm = 32'h30;
        step("to40", 32'h40, 1, 0);
        stall = 0;

        // JALR clears bit0
        pc_sel = 2'b10; rs1 = 32'h1001; imm = 32'h4;
        step("jalr", 32'h1004, 1, 0);
        rs1 = 32'h40; imm = 32'h0;
        step("jalr40", 32'h40, 1, 0);

        // misaligned branch
        pc_sel = 2'b01; imm = 32'h6; mtvec = 32'h203;
        step("misbr", 32'h200, 1, 1);
        chk("misbr_bad", bad_addr, 32'h46);
        redirect = 0;
        step("mispost", 32'h204, 1, 0);
        chk("bad_hold", bad_addr, 32'h46);

        // trap path: no alignment check
        redirect = 1; pc_sel = 2'b11;
        step("trap", 32'h200, 1, 0);

        // halt/resume
        pc_sel = 2'b01; imm = 32'hFFFF_FE80;
        step("to80", 32'h80, 1, 0);
        redirect = 0; halt = 1;
        step("halt", 32'h84, 0, 0);
        halt = 0; redirect = 1; pc_sel = 2'b11;
        step("hred", 32'h84, 0, 0);
        stall = 1;
        step("hstall", 32'h84, 0, 0);
        redirect = 0; stall = 0; resume = 1;
        step("resume", 32'h84, 1, 0);
        resume = 0;
        step("res_seq", 32'h88, 1, 0);
        halt = 1;
        step("halt2", 32'h8C, 0, 0);
        resume = 1;
        step("both1", 32'h8C, 0, 0);
        step("both2", 32'h8C, 0, 0);
        halt = 0;
        step("resume2", 32'h8C, 1, 0);
        resume = 0;

        // wrap-around
        redirect = 1; pc_sel = 2'b10; rs1 = 32'hFFFF_FFFC; imm = 32'h0;
        step("tomax", 32'hFFFF_FFFC, 1, 0);
        redirect = 0;
        step("wrap", 32'h0, 1, 0);

        // async reset mid-cycle
        redirect = 1; pc_sel = 2'b01; imm = 32'h1234;
        step("to1234", 32'h1234, 1, 0);
        redirect = 0;
        #2 rst = 1'b1;
        #1;
        chk("arst_pc", PC_out, 32'h100);
        chk("arst_fv", {31'd0, fetch_valid}, 32'd0);
        chk("arst_bad", bad_addr, 32'd0);
        #2 rst = 1'b0;

        // halt sampled in BOOT
        halt = 1;
        step("boothalt", 32'h100, 0, 0);
        halt = 0;
        step("bh_hold", 32'h100, 0, 0);
        resume = 1;
        step("bh_res", 32'h100, 1, 0);
        resume = 0;
        step("bh_seq", 32'h104, 1, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
